// File: rtl/cpu_datapath_pipe.sv
// Two-stage datapath: EX reads operands, runs ALU and shifter, and registers the result.
// WB writes that result back to the register file one cycle later, with a single-level bypass.
module cpu_datapath_pipe #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREGS = 8,
   localparam int unsigned AW   = $clog2(NREGS),
   localparam int unsigned CW   = 3 * AW + 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl_valid,
   input  logic [CW-1:0]    ctrl_word,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [3:0]       state_flags
);

   localparam int MSB = WIDTH - 1;

   logic [AW-1:0]    a_sel, b_sel, d_sel;
   logic [3:0]       f_sel;
   logic [2:0]       h_sel;

   logic [WIDTH-1:0] rf_q [NREGS];
   logic [WIDTH-1:0] rf_d [NREGS];
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [3:0]       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;
   logic             wb_pending_q, wb_pending_d;
   logic [AW-1:0]    wb_dst_q, wb_dst_d;

   logic [WIDTH-1:0] bus_a, bus_b, alu_res, shift_res;
   logic [WIDTH:0]   ext_a, ext_b, arith;
   logic             carry, ovf;

   assign {a_sel, b_sel, d_sel, f_sel, h_sel} = ctrl_word;

   // Operand select: selector 0 takes data_in, a pending writeback overrides the reg file.
   always_comb begin
      bus_a = rf_q[a_sel];
      if (wb_pending_q && (wb_dst_q == a_sel)) bus_a = data_out_q;
      if (a_sel == '0) bus_a = data_in;
      bus_b = rf_q[b_sel];
      if (wb_pending_q && (wb_dst_q == b_sel)) bus_b = data_out_q;
      if (b_sel == '0) bus_b = data_in;
   end

   always_comb begin
      ext_a   = {1'b0, bus_a};
      ext_b   = {1'b0, bus_b};
      arith   = '0;
      alu_res = '0;
      carry   = 1'b0;
      ovf     = 1'b0;
      case (f_sel)
         4'd0: alu_res = bus_a;
         4'd1: begin
            arith   = ext_a + ext_b;
            alu_res = arith[WIDTH-1:0];
            carry   = arith[WIDTH];
            ovf     = (bus_a[MSB] == bus_b[MSB]) && (alu_res[MSB] != bus_a[MSB]);
         end
         4'd2: begin
            arith   = ext_a - ext_b;
            alu_res = arith[WIDTH-1:0];
            carry   = ~arith[WIDTH];
            ovf     = (bus_a[MSB] != bus_b[MSB]) && (alu_res[MSB] != bus_a[MSB]);
         end
         4'd3: begin
            arith   = ext_a + (WIDTH+1)'(1);
            alu_res = arith[WIDTH-1:0];
            carry   = arith[WIDTH];
            ovf     = ~bus_a[MSB] & alu_res[MSB];
         end
         4'd4: begin
            arith   = ext_a - (WIDTH+1)'(1);
            alu_res = arith[WIDTH-1:0];
            carry   = ~arith[WIDTH];
            ovf     = bus_a[MSB] & ~alu_res[MSB];
         end
         4'd5: alu_res = bus_a & bus_b;
         4'd6: alu_res = bus_a | bus_b;
         4'd7: alu_res = bus_a ^ bus_b;
         4'd8: alu_res = ~bus_a;
         4'd9: alu_res = bus_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (h_sel)
         3'd1:    shift_res = {alu_res[MSB-1:0], 1'b0};
         3'd2:    shift_res = {1'b0, alu_res[MSB:1]};
         3'd3:    shift_res = {alu_res[MSB], alu_res[MSB:1]};
         3'd4:    shift_res = {alu_res[MSB-1:0], alu_res[MSB]};
         3'd5:    shift_res = {alu_res[0], alu_res[MSB:1]};
         default: shift_res = alu_res;
      endcase
   end

   always_comb begin
      rf_d         = rf_q;
      data_out_d   = data_out_q;
      flags_d      = flags_q;
      out_valid_d  = 1'b0;
      wb_pending_d = 1'b0;
      wb_dst_d     = wb_dst_q;
      if (wb_pending_q && (wb_dst_q != '0)) rf_d[wb_dst_q] = data_out_q;
      if (ctrl_valid) begin
         data_out_d   = shift_res;
         // Flags describe the ALU result before the shifter.
         flags_d      = {carry, (alu_res == '0), alu_res[MSB], ovf};
         out_valid_d  = 1'b1;
         wb_pending_d = (d_sel != '0);
         wb_dst_d     = d_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
         data_out_q   <= '0;
         flags_q      <= '0;
         out_valid_q  <= 1'b0;
         wb_pending_q <= 1'b0;
         wb_dst_q     <= '0;
      end else begin
         rf_q         <= rf_d;
         data_out_q   <= data_out_d;
         flags_q      <= flags_d;
         out_valid_q  <= out_valid_d;
         wb_pending_q <= wb_pending_d;
         wb_dst_q     <= wb_dst_d;
      end
   end

   assign data_out    = data_out_q;
   assign out_valid   = out_valid_q;
   assign state_flags = flags_q;

endmodule

// File: tb/tb_cpu_datapath_pipe.sv
// Bench for cpu_datapath_pipe (WIDTH=4, NREGS=8): directed cases then random ops,
// compared each cycle against an architectural model of the register file.
module tb_cpu_datapath_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ctrl_valid = 1'b0;
   logic [15:0] ctrl_word = '0;
   logic [3:0]  data_in = '0;
   logic [3:0]  data_out;
   logic        out_valid;
   logic [3:0]  state_flags;

   int errors = 0;
   int checks = 0;

   int         mreg [8];
   int         exp_out;
   logic       exp_valid;
   logic [3:0] exp_flags;

   cpu_datapath_pipe #(.WIDTH(4), .NREGS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl_valid  (ctrl_valid),
      .ctrl_word   (ctrl_word),
      .data_in     (data_in),
      .data_out    (data_out),
      .out_valid   (out_valid),
      .state_flags (state_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= 8) ? x - 16 : x;
   endfunction

   // Architectural meaning of one operation, in plain integer arithmetic.
   function automatic void model_op(input int av, input int bv, input int f, input int h,
                                    output int res, output logic [3:0] fl);
      int r, s;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (f)
         0: r = av;
         1: begin r = av + bv; c = (r > 15); s = sgn(av) + sgn(bv); v = (s > 7 || s < -8); end
         2: begin r = av - bv; c = (av >= bv); s = sgn(av) - sgn(bv); v = (s > 7 || s < -8); end
         3: begin r = av + 1; c = (r > 15); v = (sgn(av) + 1 > 7); end
         4: begin r = av - 1; c = (av >= 1); v = (sgn(av) - 1 < -8); end
         5: r = av & bv;
         6: r = av | bv;
         7: r = av ^ bv;
         8: r = 15 - av;
         9: r = bv;
         default: r = 0;
      endcase
      r  = (r + 16) % 16;
      fl = {c, (r == 0), (r >= 8), v};
      case (h)
         1: res = (r * 2) % 16;
         2: res = r / 2;
         3: res = r / 2 + (r & 8);
         4: res = (r * 2) % 16 + r / 8;
         5: res = r / 2 + (r % 2) * 8;
         default: res = r;
      endcase
   endfunction

   // Drive one cycle, advance the model, then compare outputs away from the edge.
   task automatic issue(input logic r, input logic v, input int a, input int b, input int d,
                        input int f, input int h, input int din);
      int         av, bv, res;
      logic [3:0] fl;
      rst        = r;
      ctrl_valid = v;
      ctrl_word  = {3'(a), 3'(b), 3'(d), 4'(f), 3'(h)};
      data_in    = 4'(din);
      av = (a == 0) ? din : mreg[a];
      bv = (b == 0) ? din : mreg[b];
      @(posedge clk);
      #1;
      if (r) begin
         foreach (mreg[i]) mreg[i] = 0;
         exp_out   = 0;
         exp_flags = '0;
         exp_valid = 1'b0;
      end else if (v) begin
         model_op(av, bv, f, h, res, fl);
         exp_out   = res;
         exp_flags = fl;
         exp_valid = 1'b1;
         if (d != 0) mreg[d] = res;
      end else begin
         exp_valid = 1'b0;
      end
      check("data_out", 8'(data_out), 8'(exp_out));
      check("out_valid", 8'(out_valid), 8'(exp_valid));
      check("flags", 8'(state_flags), 8'(exp_flags));
      rst        = 1'b0;
      ctrl_valid = 1'b0;
   endtask

   initial begin
      foreach (mreg[i]) mreg[i] = 0;
      exp_out   = 0;
      exp_flags = '0;
      exp_valid = 1'b0;

      // Reset and read back every register
      issue(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
      check("rst_data_out", 8'(data_out), 8'h0);
      check("rst_out_valid", 8'(out_valid), 8'h0);
      check("rst_flags", 8'(state_flags), 8'h0);
      for (int r = 1; r < 8; r++) begin
         issue(1'b0, 1'b1, r, 0, 0, 0, 0, 9);
         check("rst_reg", 8'(data_out), 8'h0);
      end

      // Load, then read from the register file
      issue(1'b0, 1'b1, 0, 0, 1, 0, 0, 5);
      check("load", 8'(data_out), 8'h5);
      check("load_z", 8'(state_flags[2]), 8'h0);
      issue(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
      issue(1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
      check("load_read", 8'(data_out), 8'h5);

      // Bypass: consumer directly behind producer
      issue(1'b0, 1'b1, 0, 0, 1, 0, 0, 5);
      issue(1'b0, 1'b1, 1, 1, 2, 1, 0, 0);
      check("bypass", 8'(data_out), 8'hA);
      check("bypass_flags", 8'(state_flags), 8'b0011);

      // Carry and zero
      issue(1'b0, 1'b1, 0, 0, 1, 0, 0, 15);
      issue(1'b0, 1'b1, 1, 0, 0, 1, 0, 1);
      check("carry", 8'(data_out), 8'h0);
      check("carry_flags", 8'(state_flags), 8'b1100);

      // Shifter on 0x9
      issue(1'b0, 1'b1, 0, 0, 1, 0, 0, 9);
      issue(1'b0, 1'b1, 1, 0, 0, 0, 3, 0);
      check("asr", 8'(data_out), 8'hC);
      check("shift_flags", 8'(state_flags), 8'b0010);
      issue(1'b0, 1'b1, 1, 0, 0, 0, 4, 0);
      check("rol", 8'(data_out), 8'h3);
      issue(1'b0, 1'b1, 1, 0, 0, 0, 5, 0);
      check("ror", 8'(data_out), 8'hC);
      issue(1'b0, 1'b1, 1, 0, 0, 0, 2, 0);
      check("lsr", 8'(data_out), 8'h4);
      check("lsr_flags", 8'(state_flags), 8'b0010);

      // Bubble holds data_out; reset during pending writeback drops it
      issue(1'b0, 1'b1, 0, 0, 3, 0, 0, 6);
      issue(1'b0, 1'b0, 1, 1, 0, 1, 0, 0);
      check("bubble_valid", 8'(out_valid), 8'h0);
      check("bubble_hold", 8'(data_out), 8'h6);
      issue(1'b0, 1'b1, 3, 0, 0, 0, 0, 0);
      check("bubble_wb", 8'(data_out), 8'h6);
      issue(1'b0, 1'b1, 0, 0, 3, 0, 0, 7);
      issue(1'b1, 1'b1, 0, 0, 3, 0, 0, 11);
      check("rst_wins_valid", 8'(out_valid), 8'h0);
      issue(1'b0, 1'b1, 3, 0, 0, 0, 0, 0);
      check("rst_drop_wb", 8'(data_out), 8'h0);

      // Random ops against the model
      for (int i = 0; i < 600; i++) begin
         issue(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
